// File: rtl/rr_bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: bus polarity constants,
// the two-state FSM encoding and the default sizing used by the top level.
package rr_bus_arbiter_pkg;

  // Bus request/grant lines are active-low.
  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  typedef enum logic [0:0] {
    ArbIdle  = 1'b0,
    ArbOwned = 1'b1
  } arb_state_e;

  localparam int unsigned DefNreq   = 2;
  localparam int unsigned DefOwnw   = 3;
  localparam int unsigned DefMaxten = 16;

endpackage

// File: rtl/rr_bus_arbiter_rr_pick.sv
// Combinational rotating-priority encoder. The search starts one past the
// last winner and wraps, so the last winner ranks lowest.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned OWNW = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [OWNW-1:0] last_i,
  output logic [OWNW-1:0] winner_o,
  output logic            found_o
);

  int              idx;
  logic [NREQ-1:0] shifted;

  // Scan candidates in rotating order; the first active request wins.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    shifted  = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      idx     = (int'(last_i) + i) % int'(NREQ);
      shifted = req_i >> idx;
      if (!found_o && shifted[0]) begin
        found_o  = 1'b1;
        winner_o = OWNW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the shared device bus. Active-low requests in,
// registered one-hot active-low grants out, plus the owner index for the
// address/data mux. Define BUSARB_TIMEOUT_EN to bound grant tenure to MAXTEN
// cycles while other masters are waiting.
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = DefNreq,
  parameter int unsigned OWNW   = DefOwnw,
  parameter int unsigned MAXTEN = DefMaxten
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic [NREQ-1:0] breq_,
  output logic [NREQ-1:0] bgrt_,
  output logic [OWNW-1:0] owner,
  output logic            busy
);

  if (NREQ < 2 || NREQ > 8 || (1 << OWNW) < NREQ || MAXTEN < 2) begin : gen_param_check
    $error("rr_bus_arbiter: invalid NREQ/OWNW/MAXTEN combination");
  end

  localparam logic [NREQ-1:0] OneHot0 = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e      state_q, state_d;
  logic [OWNW-1:0] owner_q, owner_d;
  logic [OWNW-1:0] last_q, last_d;
  logic [NREQ-1:0] bgrt_q, bgrt_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] own_oh;
  logic [NREQ-1:0] pick_req;
  logic [OWNW-1:0] win;
  logic            found;
  logic            owner_rel;
  logic            timeout;

  assign req       = ~(breq_ ^ {NREQ{Enable_}});
  assign own_oh    = OneHot0 << owner_q;
  assign owner_rel = ~|(own_oh & req);
  // While owned, only other masters compete; this also makes a re-request by
  // the releasing owner rank last.
  assign pick_req  = (state_q == ArbOwned) ? (req & ~own_oh) : req;

  rr_pick #(
    .NREQ(NREQ),
    .OWNW(OWNW)
  ) u_pick (
    .req_i   (pick_req),
    .last_i  (last_q),
    .winner_o(win),
    .found_o (found)
  );

`ifdef BUSARB_TIMEOUT_EN
  localparam int unsigned     CntW    = (MAXTEN > 2) ? $clog2(MAXTEN) : 1;
  localparam logic [CntW-1:0] TenLast = CntW'(MAXTEN - 1);

  logic [CntW-1:0] ten_q, ten_d;

  // Tenure counter: clears on any new grant, saturates at MAXTEN-1.
  always_comb begin
    ten_d = ten_q;
    if (state_d == ArbOwned && (state_q == ArbIdle || owner_d != owner_q)) begin
      ten_d = '0;
    end else if (state_q == ArbOwned && ten_q != TenLast) begin
      ten_d = ten_q + 1'b1;
    end
  end

  // Tenure counter register.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      ten_q <= '0;
    end else begin
      ten_q <= ten_d;
    end
  end

  assign timeout = (state_q == ArbOwned) && (ten_q == TenLast);
`else
  assign timeout = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= ArbIdle;
      owner_q <= '0;
      last_q  <= OWNW'(NREQ - 1);
      bgrt_q  <= {NREQ{Disable_}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bgrt_q  <= bgrt_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: grant from idle, hold while the owner requests, regrant or
  // drop to idle on release (or forced rotation on timeout).
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ArbIdle: begin
        if (found) begin
          state_d = ArbOwned;
          owner_d = win;
          last_d  = win;
        end
      end
      ArbOwned: begin
        if (owner_rel || timeout) begin
          if (found) begin
            owner_d = win;
            last_d  = win;
          end else if (owner_rel) begin
            state_d = ArbIdle;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Output decode of the next state, registered above so grants are glitch-free.
  always_comb begin
    bgrt_d = {NREQ{Disable_}};
    busy_d = 1'b0;
    if (state_d == ArbOwned) begin
      bgrt_d = ~(OneHot0 << owner_d);
      busy_d = 1'b1;
    end
  end

  assign bgrt_ = bgrt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter for the shared device bus in the multi-CPU system.
- Takes active-low bus requests from NREQ mips32 cores and issues one-hot active-low grants.
- The top-level address/data/rw_ mux selects the granted core's signals.
- Replaces the fixed two-master arbitration with fair, registered, glitch-free grants, plus an owner index for the mux.

Parameters:
- NREQ, 2, number of requesting masters (2..8).
- OWNW, 3, width of owner index; must satisfy 2**OWNW >= NREQ.
- MAXTEN, 16, maximum grant tenure in cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_  input  1  synchronous, active-low reset (sampled on rising edge of clk).
- breq_  input  NREQ  per-master bus request, active-low (`Enable_ = 0`).
- bgrt_  output  NREQ  per-master bus grant, active-low, at most one bit low.
- owner  output  OWNW  index of the current grant holder; valid when busy = 1.
- busy  output  1  high while any grant is asserted.

Behaviour:
- Reset (reset_ = 0 at a clock edge):
  - bgrt_ = all ones, busy = 0, owner = 0.
  - last-owner pointer = NREQ-1, so master 0 has top priority after reset.
  - Reset mid-tenure drops the grant on that same edge.
- All outputs are registered; no combinational path from breq_ to bgrt_.
- State machine, two states:
  - IDLE:
    - If any breq_ bit is 0, grant the winner next cycle and go to OWNED.
    - Latency from request to bgrt_ low is exactly 1 cycle.
  - OWNED:
    - Grant holds while the owner's breq_ bit stays 0; other requests are ignored.
    - When the owner releases (breq_ bit = 1), on that edge the arbiter either regrants or goes to IDLE.
    - Regrant: if another master is requesting, pick the round-robin winner and update bgrt_/owner on that edge (zero dead cycles). The releasing master's grant goes high on the same edge.
    - Otherwise go to IDLE with bgrt_ all ones.
- Round-robin rule:
  - Search starts at (last+1) mod NREQ and wraps; the first requester found wins.
  - last := winner whenever a grant is issued.
  - Wrap-around: with NREQ = 2 and last = 1, master 0 is checked first.
- Simultaneous requests: resolved only by the rotating priority; a single requester always wins regardless of the pointer.
- Release and re-request by the same master:
  - The owner must see at least one cycle with its breq_ = 1 to end its tenure.
  - If it re-requests while others are waiting, it ranks last.
- owner and busy change on the same edge as bgrt_; owner holds its value in IDLE.
- Invariant: bgrt_ is all ones or has exactly one zero bit, and that bit is at index owner.

Optional Feature:
- Macro: BUSARB_TIMEOUT_EN.
- When defined:
  - A tenure counter clears on each new grant and increments each OWNED cycle.
  - When it reaches MAXTEN-1 and any other master is requesting, the grant is forcibly rotated to the round-robin winner on the next edge, as if the owner had released. The owner's request stays pending.
  - If no other master is requesting, the counter saturates and the owner keeps the bus.
- When undefined:
  - No counter logic; tenure is unbounded and MAXTEN is unused.

Decomposition:
- Shared header define.h:
  - `Enable_`/`Disable_` polarity constants.
  - State encodings ARB_IDLE/ARB_OWNED.
  - Default NREQ/OWNW values used by top.
- One natural sub-module: rr_pick.
  - Combinational rotating-priority encoder.
  - Inputs: request vector (active-high), last pointer.
  - Outputs: winner index, found flag.
  - Instantiated once.

Test Plan:
- Reset then idle: reset_ low 2 cycles, breq_ = 2'b11 → bgrt_ = 2'b11, busy = 0, owner = 0 throughout.
- Single request latency: breq_ = 2'b10 at cycle 5 → bgrt_ = 2'b10, owner = 0, busy = 1 at cycle 6. Release at cycle 9 → bgrt_ = 2'b11 at cycle 10.
- Simultaneous and fairness: after reset, breq_ = 2'b00 continuously, each master releasing after 3 owned cycles → grants alternate 0,1,0,1 with no idle cycle between tenures.
- Hold under contention: master 1 owns, master 0 requests for 20 cycles → bgrt_ stays 2'b01 until master 1 releases, then 2'b10 on the release edge.
- Reset mid-tenure: reset_ low while owner = 1 → bgrt_ = 2'b11 on that edge; after reset, simultaneous requests grant master 0.
- BUSARB_TIMEOUT_EN, MAXTEN = 4: both masters request continuously, never releasing → grant rotates every 4 cycles. With only master 0 requesting, it holds the bus indefinitely.
